// File: rtl/timeout_scheduler_if.sv
// Requester-side bundle for the shared timeout counter: requests, lengths,
// cancels in; grant, done pulse, owner index and debug status out.
interface timeout_scheduler_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_WIDTH = 16
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*CNT_WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]           cancel;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic [ID_WIDTH-1:0]          owner_id;
  logic                         busy;
  logic [CNT_WIDTH-1:0]         cnt_value;

  // Requesters drive requests and cancels, observe the scheduler outputs.
  modport master (
    output req, req_len, cancel,
    input  grant, done, owner_id, busy, cnt_value
  );

  // The scheduler consumes requests and drives all status outputs.
  modport slave (
    input  req, req_len, cancel,
    output grant, done, owner_id, busy, cnt_value
  );
endinterface

// File: rtl/timeout_scheduler.sv
// Round-robin owner of a single timeout counter. One requester at a time is
// granted the counter, which runs for max(len,1) cycles and then returns a
// one-cycle done pulse to that owner. The owner may cancel at any time.
module timeout_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  timeout_scheduler_if.slave bus
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [ID_WIDTH-1:0]  owner_q, owner_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 busy_q, busy_d;

  logic                 found;
  int unsigned          idx;
  int unsigned          pick;
  logic [CNT_WIDTH-1:0] len_pick;

  // Round-robin search starting just after the last owner, then next-state logic.
  always_comb begin
    found = 1'b0;
    idx   = 0;
    pick  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(owner_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    len_pick = bus.req_len[CNT_WIDTH*pick +: CNT_WIDTH];

    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    len_d   = len_q;

    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (found) begin
          state_d = StCount;
          grant_d = NUM_REQ'(1) << pick;
          owner_d = ID_WIDTH'(pick);
          cnt_d   = '0;
          // A zero length still occupies the counter for one cycle.
          len_d   = (len_pick == '0) ? CNT_WIDTH'(1) : len_pick;
        end
      end
      StCount: begin
        if (bus.cancel[owner_q]) begin
          // Cancel beats a coincident terminal count: no done pulse.
          grant_d = '0;
          state_d = StIdle;
        end else if (cnt_q == len_q - CNT_WIDTH'(1)) begin
          grant_d = '0;
          done_d  = NUM_REQ'(1) << owner_q;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; synchronous reset discards any running timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= ID_WIDTH'(NUM_REQ - 1);
      cnt_q   <= '0;
      len_q   <= CNT_WIDTH'(1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.owner_id  = owner_q;
  assign bus.busy      = busy_q;
  assign bus.cnt_value = cnt_q;

endmodule

// File: tb/tb_timeout_scheduler.sv
// Directed bench for timeout_scheduler: a table of single-owner transactions
// followed by hand-written multi-cycle sequences.
module tb_timeout_scheduler;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 16;

  logic clk;
  logic rst;

  timeout_scheduler_if #(.NUM_REQ(NR), .CNT_WIDTH(CW)) bus ();

  timeout_scheduler #(.NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    int          cancel_at;   // grant cycle on which owner cancels, 0 = never
    int          exp_owner;
    int          exp_cycles;
    bit          exp_done;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [3:0] oh(input int i);
    logic [3:0] r;
    r = 4'b0001 << i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_len(input logic [15:0] len);
    for (int i = 0; i < 4; i++) bus.req_len[i*16 +: 16] = len;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((bus.busy || bus.done != 0 || bus.grant != 0) && b < 50) begin
      step();
      b++;
    end
    check("idle_wait", {31'd0, bus.busy}, 32'd0);
  endtask

  // Waits for a grant, with a cycle budget; returns 1 if one arrived.
  task automatic wait_grant(input string name, output bit ok);
    int b;
    b = 0;
    step();
    while (bus.grant == 0 && b < 20) begin
      step();
      b++;
    end
    ok = (bus.grant != 0);
    if (!ok) check(name, 32'd0, 32'd1);
  endtask

  task automatic run_txn(input vec_t v, input int n);
    bit ok;
    int hi;
    bus.req = v.req;
    set_all_len(v.len);
    wait_grant($sformatf("v%0d_grant_wait", n), ok);
    if (!ok) begin
      bus.req = '0;
      return;
    end
    check($sformatf("v%0d_grant", n), bus.grant, oh(v.exp_owner));
    check($sformatf("v%0d_owner", n), bus.owner_id, v.exp_owner);
    check($sformatf("v%0d_busy", n), bus.busy, 1);
    bus.req = '0;  // dropping req must not end the timeout
    hi = 1;
    forever begin
      check($sformatf("v%0d_cnt", n), bus.cnt_value, hi - 1);
      if (hi == v.cancel_at) bus.cancel = oh(v.exp_owner);
      step();
      bus.cancel = '0;
      if (bus.grant == 0 || hi > v.exp_cycles + 4) break;
      hi++;
    end
    check($sformatf("v%0d_grant_cycles", n), hi, v.exp_cycles);
    check($sformatf("v%0d_done", n), bus.done, v.exp_done ? oh(v.exp_owner) : 4'b0);
    step();
    check($sformatf("v%0d_done_clear", n), bus.done, 0);
    check($sformatf("v%0d_busy_clear", n), bus.busy, 0);
  endtask

  initial begin
    bit          ok;
    int          hi;
    int          low;
    int          rr_exp[5];
    logic [15:0] max_cnt;
    logic [15:0] prev_cnt;
    bit          wrapped;

    vecs[0] = '{req: 4'b0001, len: 16'd5, cancel_at: 0, exp_owner: 0, exp_cycles: 5, exp_done: 1};
    vecs[1] = '{req: 4'b0001, len: 16'd0, cancel_at: 0, exp_owner: 0, exp_cycles: 1, exp_done: 1};
    vecs[2] = '{req: 4'b0001, len: 16'd1, cancel_at: 0, exp_owner: 0, exp_cycles: 1, exp_done: 1};
    vecs[3] = '{req: 4'b0110, len: 16'd2, cancel_at: 0, exp_owner: 1, exp_cycles: 2, exp_done: 1};
    vecs[4] = '{req: 4'b0110, len: 16'd3, cancel_at: 0, exp_owner: 2, exp_cycles: 3, exp_done: 1};
    vecs[5] = '{req: 4'b1001, len: 16'd4, cancel_at: 2, exp_owner: 3, exp_cycles: 2, exp_done: 0};
    vecs[6] = '{req: 4'b1111, len: 16'd2, cancel_at: 0, exp_owner: 0, exp_cycles: 2, exp_done: 1};
    // Cancel on the same edge as the terminal count: cancel wins.
    vecs[7] = '{req: 4'b0100, len: 16'd7, cancel_at: 7, exp_owner: 2, exp_cycles: 7, exp_done: 0};
    vecs[8] = '{req: 4'b1000, len: 16'd3, cancel_at: 0, exp_owner: 3, exp_cycles: 3, exp_done: 1};

    bus.req    = '0;
    bus.cancel = '0;
    set_all_len(16'd0);
    rst = 1'b1;
    step();
    check("rst_grant", bus.grant, 0);
    check("rst_done", bus.done, 0);
    check("rst_owner", bus.owner_id, 3);
    check("rst_busy", bus.busy, 0);
    check("rst_cnt", bus.cnt_value, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

    // Round robin with all four requesting, len 3: order 0,1,2,3,0, 2-cycle gaps.
    rr_exp = '{0, 1, 2, 3, 0};
    bus.req = 4'b1111;
    set_all_len(16'd3);
    step();
    for (int g = 0; g < 5; g++) begin
      low = 0;
      while (bus.grant == 0 && low < 20) begin
        low++;
        step();
      end
      if (g > 0) check("rr_gap", low, 2);
      check("rr_grant", bus.grant, oh(rr_exp[g]));
      hi = 0;
      while (bus.grant != 0 && hi < 20) begin
        if (bus.done != 0) check("rr_overlap", bus.done, 0);
        hi++;
        step();
      end
      check("rr_len", hi, 3);
      check("rr_done", bus.done, oh(rr_exp[g]));
    end
    bus.req = '0;
    wait_idle();

    // Cancel: req2 len 10, non-owner cancel1 ignored, owner cancels on cycle 4.
    bus.req = 4'b0100;
    set_all_len(16'd10);
    wait_grant("cx_grant_wait", ok);
    check("cx_grant", bus.grant, 4'b0100);
    bus.req = 4'b0110;
    bus.req_len[16 +: 16] = 16'd1;
    step();                      // grant cycle 2
    bus.cancel = 4'b0010;
    step();                      // grant cycle 3
    bus.cancel = '0;
    check("cx_ignore_cancel1", bus.grant, 4'b0100);
    check("cx_cnt", bus.cnt_value, 2);
    step();                      // grant cycle 4
    bus.cancel = 4'b0100;
    step();
    bus.cancel = '0;
    check("cx_grant_drop", bus.grant, 0);
    check("cx_no_done", bus.done, 0);
    step();
    check("cx_next_grant", bus.grant, 4'b0010);
    check("cx_next_owner", bus.owner_id, 1);
    bus.req = '0;
    step();
    check("cx_next_done", bus.done, 4'b0010);
    wait_idle();

    // req_len change after grant must not alter the running timeout.
    bus.req = 4'b0001;
    bus.req_len[0 +: 16] = 16'd4;
    wait_grant("lc_grant_wait", ok);
    check("lc_grant", bus.grant, 4'b0001);
    bus.req_len[0 +: 16] = 16'd1;
    bus.req = '0;
    hi = 1;
    step();
    while (bus.grant != 0 && hi < 20) begin
      hi++;
      step();
    end
    check("lc_len", hi, 4);
    check("lc_done", bus.done, 4'b0001);
    wait_idle();

    // Maximum length: 65535 grant cycles, counter peaks at FFFE, no wrap.
    bus.req = 4'b1000;
    bus.req_len[48 +: 16] = 16'hFFFF;
    wait_grant("mx_grant_wait", ok);
    check("mx_grant", bus.grant, 4'b1000);
    bus.req  = '0;
    hi       = 1;
    max_cnt  = bus.cnt_value;
    prev_cnt = bus.cnt_value;
    wrapped  = 1'b0;
    step();
    while (bus.grant != 0 && hi < 70000) begin
      if (bus.cnt_value < prev_cnt) wrapped = 1'b1;
      if (bus.cnt_value > max_cnt) max_cnt = bus.cnt_value;
      prev_cnt = bus.cnt_value;
      hi++;
      step();
    end
    check("mx_len", hi, 65535);
    check("mx_max_cnt", max_cnt, 16'hFFFE);
    check("mx_no_wrap", {31'd0, wrapped}, 0);
    check("mx_done", bus.done, 4'b1000);
    check("mx_cnt_clear", bus.cnt_value, 0);
    wait_idle();

    // Reset on grant cycle 4 of an 8-cycle timeout.
    bus.req = 4'b1111;
    set_all_len(16'd8);
    wait_grant("rs_grant_wait", ok);
    check("rs_grant", bus.grant, 4'b0001);
    step();
    step();
    step();                      // grant cycle 4
    check("rs_cnt_before", bus.cnt_value, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_grant_clr", bus.grant, 0);
    check("rs_done_clr", bus.done, 0);
    check("rs_owner", bus.owner_id, 3);
    check("rs_busy", bus.busy, 0);
    check("rs_cnt", bus.cnt_value, 0);
    step();
    check("rs_first_winner", bus.grant, 4'b0001);
    check("rs_no_done", bus.done, 0);
    bus.req = '0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
